// File: rtl/axi4_switch_custom_pkg.sv
// -----------------------------------------------------------------------------
// axi4_switch_custom_pkg
// Shared definitions for the 2:1 AXI4-Stream packet switch:
//   - arb_state_t : arbiter state encoding (IDLE / LOCK0 / LOCK1)
//   - default data/user/keep widths
//   - slave port index constants
// -----------------------------------------------------------------------------
package axi4_switch_custom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int TDATA_DEF = 512;
    localparam int TUSER_DEF = 81;
    localparam int TKEEP_DEF = 16;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

endpackage

// File: rtl/axi4_switch_custom_arb.sv
// -----------------------------------------------------------------------------
// axi4_switch_custom_arb
// Packet-level round-robin arbiter for two slave ports.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req         : per-port tvalid
//   supress     : per-port request mask, only honoured in IDLE
//   handshake   : a beat of the granted port transferred this cycle
//   tlast       : tlast of the granted port's current beat
//   grant       : one-hot grant (combinational in IDLE, fixed while locked)
// -----------------------------------------------------------------------------
module axi4_switch_custom_arb
    import axi4_switch_custom_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] supress,
    input  logic       handshake,
    input  logic       tlast,
    output logic [1:0] grant
);

    arb_state_t state;
    logic       prio;   // port currently holding round-robin priority
    logic [1:0] elig;

    always_comb begin
        elig  = req & ~supress;
        grant = '0;
        case (state)
            IDLE: begin
                if (elig == 2'b11) begin
                    grant = prio ? 2'b10 : 2'b01;
                end else begin
                    grant = elig;
                end
            end
            LOCK0:   grant = 2'b01;
            LOCK1:   grant = 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else if (handshake) begin
            if (tlast) begin
                // packet finished: release lock, priority goes to the other port
                state <= IDLE;
                prio  <= grant[PORT0];
            end else if (state == IDLE) begin
                state <= grant[PORT1] ? LOCK1 : LOCK0;
            end
        end
    end

endmodule

// File: rtl/axi4_switch_custom.sv
// -----------------------------------------------------------------------------
// axi4_switch_custom
// 2:1 AXI4-Stream packet switch. Whole packets from slave ports s0/s1 are
// forwarded to master port m0 without interleaving, round-robin between
// packets.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   s_req_supress     : bit n masks new arbitration requests from slave n
//   axi_s0_* / axi_s1_*: slave stream inputs (tdata/tuser/tlast/tkeep/tvalid),
//                       tready outputs
//   axi_m0_*          : master stream outputs, tready input
// Build option:
//   AXI4_SWITCH_CUSTOM_OUTREG_EN - when defined, m0 is driven from a 2-entry
//   skid register slice (1-cycle latency, full throughput); otherwise m0 is a
//   zero-latency mux of the granted slave.
// -----------------------------------------------------------------------------
module axi4_switch_custom
    import axi4_switch_custom_pkg::*;
#(
    parameter int TDATA_L = TDATA_DEF,
    parameter int TUSER_L = TUSER_DEF,
    parameter int TKEEP_L = TKEEP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         s_req_supress,
    input  logic [TDATA_L-1:0] axi_s0_tdata_i,
    input  logic [TUSER_L-1:0] axi_s0_tuser_i,
    input  logic               axi_s0_tlast_i,
    input  logic [TKEEP_L-1:0] axi_s0_tkeep_i,
    input  logic               axi_s0_tvalid_i,
    output logic               axi_s0_tready_o,
    input  logic [TDATA_L-1:0] axi_s1_tdata_i,
    input  logic [TUSER_L-1:0] axi_s1_tuser_i,
    input  logic               axi_s1_tlast_i,
    input  logic [TKEEP_L-1:0] axi_s1_tkeep_i,
    input  logic               axi_s1_tvalid_i,
    output logic               axi_s1_tready_o,
    output logic [TDATA_L-1:0] axi_m0_tdata_o,
    output logic [TUSER_L-1:0] axi_m0_tuser_o,
    output logic               axi_m0_tlast_o,
    output logic [TKEEP_L-1:0] axi_m0_tkeep_o,
    output logic               axi_m0_tvalid_o,
    input  logic               axi_m0_tready_i
);

    logic [1:0]         grant;
    logic               core_ready;   // switch core may accept a beat this cycle
    logic               handshake;
    logic               sel_valid;
    logic               sel_last;
    logic [TDATA_L-1:0] sel_data;
    logic [TUSER_L-1:0] sel_user;
    logic [TKEEP_L-1:0] sel_keep;

    axi4_switch_custom_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({axi_s1_tvalid_i, axi_s0_tvalid_i}),
        .supress   (s_req_supress),
        .handshake (handshake),
        .tlast     (sel_last),
        .grant     (grant)
    );

    // Granted-port mux; everything reads as zero when nothing is granted.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_user  = '0;
        sel_keep  = '0;
        if (grant[PORT0]) begin
            sel_valid = rst_n & axi_s0_tvalid_i;
            sel_last  = axi_s0_tlast_i;
            sel_data  = axi_s0_tdata_i;
            sel_user  = axi_s0_tuser_i;
            sel_keep  = axi_s0_tkeep_i;
        end else if (grant[PORT1]) begin
            sel_valid = rst_n & axi_s1_tvalid_i;
            sel_last  = axi_s1_tlast_i;
            sel_data  = axi_s1_tdata_i;
            sel_user  = axi_s1_tuser_i;
            sel_keep  = axi_s1_tkeep_i;
        end
    end

    assign handshake       = sel_valid & core_ready;
    assign axi_s0_tready_o = rst_n & grant[PORT0] & core_ready;
    assign axi_s1_tready_o = rst_n & grant[PORT1] & core_ready;

`ifdef AXI4_SWITCH_CUSTOM_OUTREG_EN
    localparam int BEAT_W = TDATA_L + TUSER_L + TKEEP_L + 1;

    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] out_beat;
    logic [BEAT_W-1:0] skid_beat;
    logic              out_valid;
    logic              skid_valid;

    assign in_beat    = {sel_data, sel_user, sel_keep, sel_last};
    // Space exists whenever the skid entry is free, so the slave side never
    // sees axi_m0_tready_i combinationally.
    assign core_ready = ~skid_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_beat   <= '0;
            skid_beat  <= '0;
        end else if (!out_valid || axi_m0_tready_i) begin
            // output register frees up: refill from skid first, else from input
            if (skid_valid) begin
                out_beat   <= skid_beat;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= sel_valid;
                if (sel_valid) begin
                    out_beat <= in_beat;
                end
            end
        end else if (handshake) begin
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign {axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tkeep_o, axi_m0_tlast_o} = out_beat;
    assign axi_m0_tvalid_o = rst_n & out_valid;
`else
    assign core_ready      = axi_m0_tready_i;
    assign axi_m0_tdata_o  = sel_data;
    assign axi_m0_tuser_o  = sel_user;
    assign axi_m0_tkeep_o  = sel_keep;
    assign axi_m0_tlast_o  = sel_last;
    assign axi_m0_tvalid_o = sel_valid;
`endif

endmodule

// File: tb/tb_axi4_switch_custom.sv
// -----------------------------------------------------------------------------
// tb_axi4_switch_custom
// Randomized packet traffic on both slave ports against a packet-level
// reference model (owner / round-robin priority / outstanding-beat count).
// The model pushes each beat it expects to be accepted into a scoreboard
// queue; a separate monitor pops and compares on every m0 transfer.
// -----------------------------------------------------------------------------
module tb_axi4_switch_custom;

    localparam int DW = 64;
    localparam int UW = 16;
    localparam int KW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    sup = 2'b00;
    beat_t         cur [2];
    logic [1:0]    s_valid = 2'b00;
    logic [1:0]    s_ready;
    logic [DW-1:0] m_data;
    logic [UW-1:0] m_user;
    logic [KW-1:0] m_keep;
    logic          m_last;
    logic          m_valid;
    logic          m_ready = 1'b0;

    int    n_checks = 0;
    int    n_fail = 0;
    int    beats_in = 0;
    int    beats_out = 0;
    beat_t sb[$];

    // reference model state
    int         owner = -1;
    int         prio = 0;
    int         inflight = 0;
    logic [1:0] xfer_pred = 2'b00;

    always #5 clk = ~clk;

    axi4_switch_custom #(
        .TDATA_L (DW),
        .TUSER_L (UW),
        .TKEEP_L (KW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_req_supress   (sup),
        .axi_s0_tdata_i  (cur[0].d),
        .axi_s0_tuser_i  (cur[0].u),
        .axi_s0_tlast_i  (cur[0].l),
        .axi_s0_tkeep_i  (cur[0].k),
        .axi_s0_tvalid_i (s_valid[0]),
        .axi_s0_tready_o (s_ready[0]),
        .axi_s1_tdata_i  (cur[1].d),
        .axi_s1_tuser_i  (cur[1].u),
        .axi_s1_tlast_i  (cur[1].l),
        .axi_s1_tkeep_i  (cur[1].k),
        .axi_s1_tvalid_i (s_valid[1]),
        .axi_s1_tready_o (s_ready[1]),
        .axi_m0_tdata_o  (m_data),
        .axi_m0_tuser_o  (m_user),
        .axi_m0_tlast_o  (m_last),
        .axi_m0_tkeep_o  (m_keep),
        .axi_m0_tvalid_o (m_valid),
        .axi_m0_tready_i (m_ready)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: evaluated mid-cycle on the inputs the bench is driving.
    always @(negedge clk) begin
        int   g;
        bit   e0, e1, cr, ev, x, pop;
        if (!rst_n) begin
            check("rst_s0_tready", s_ready[0], 0);
            check("rst_s1_tready", s_ready[1], 0);
            check("rst_m0_tvalid", m_valid, 0);
            owner     = -1;
            prio      = 0;
            inflight  = 0;
            beats_in -= sb.size();
            sb.delete();
            xfer_pred = 2'b00;
        end else begin
            if (owner >= 0) begin
                g = owner;
            end else begin
                e0 = s_valid[0] && !sup[0];
                e1 = s_valid[1] && !sup[1];
                if (e0 && e1)  g = prio;
                else if (e0)   g = 0;
                else if (e1)   g = 1;
                else           g = -1;
            end
`ifdef AXI4_SWITCH_CUSTOM_OUTREG_EN
            cr = (inflight < 2);
            ev = (inflight >= 1);
`else
            cr = m_ready;
            ev = (g >= 0) && s_valid[g];
            if (g < 0) begin
                check("idle_m0_zero", {m_data, m_user, m_keep, m_last}, 0);
            end else if (s_valid[g]) begin
                check("m0_passthrough", {m_data, m_user, m_keep, m_last}, cur[g]);
            end
`endif
            check("s0_tready", s_ready[0], (g == 0) && cr);
            check("s1_tready", s_ready[1], (g == 1) && cr);
            check("m0_tvalid", m_valid, ev);
            x = (g >= 0) && s_valid[g] && cr;
            xfer_pred = {x && (g == 1), x && (g == 0)};
            if (x) begin
                sb.push_back(cur[g]);
                beats_in++;
                if (cur[g].l) begin
                    owner = -1;
                    prio  = 1 - g;
                end else begin
                    owner = g;
                end
            end
            pop      = (inflight >= 1) && m_ready;
            inflight = inflight + int'(x) - int'(pop);
        end
    end

    // Output monitor: pops the scoreboard on every m0 transfer.
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        #1;
        if (rst_n && m_valid && m_ready) begin
            beats_out++;
            got = {m_data, m_user, m_keep, m_last};
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat at %0t: got %0h expected none", $time, got);
            end else begin
                exp = sb.pop_front();
                check("m0_beat", got, exp);
            end
        end
    end

    initial begin
        int  remaining [2];
        bit  have [2];
        bit  stop;
        remaining[0] = 0; remaining[1] = 0;
        have[0] = 0; have[1] = 0;
        stop = 0;
        cur[0] = '0; cur[1] = '0;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int phase = 0; phase < 5; phase++) begin
            for (int cyc = 0; cyc < 2000; cyc++) begin
                @(posedge clk);
                #2;
                stop = (phase == 4);
                for (int n = 0; n < 2; n++) begin
                    if (xfer_pred[n]) begin
                        have[n] = 0;
                        remaining[n]--;
                    end
                    if (stop) begin
                        have[n] = 0;
                    end else if (!have[n]) begin
                        if (remaining[n] == 0 && $urandom_range(0, 3) == 0)
                            remaining[n] = $urandom_range(1, 4);
                        if (remaining[n] > 0 && $urandom_range(0, 3) != 0) begin
                            cur[n].d = {$urandom, $urandom};
                            cur[n].u = UW'($urandom);
                            cur[n].k = KW'($urandom);
                            cur[n].l = (remaining[n] == 1);
                            have[n]  = 1;
                        end
                    end
                    s_valid[n] = have[n];
                end
                case (phase)
                    0: begin
                        m_ready = ($urandom_range(0, 3) != 0);
                        if ($urandom_range(0, 15) == 0) sup = 2'($urandom);
                        rst_n = 1'b1;
                    end
                    1: begin
                        m_ready = 1'b1;
                        sup     = (cyc < 1000) ? 2'b01 : 2'b00;
                        rst_n   = 1'b1;
                    end
                    2: begin
                        m_ready = !((cyc % 20) >= 8 && (cyc % 20) < 13);
                        sup     = 2'b00;
                        rst_n   = 1'b1;
                    end
                    3: begin
                        m_ready = ($urandom_range(0, 2) != 0);
                        if ($urandom_range(0, 15) == 0) sup = 2'($urandom);
                        rst_n = ($urandom_range(0, 99) != 0);
                    end
                    default: begin
                        m_ready = 1'b1;
                        sup     = 2'b00;
                        rst_n   = 1'b1;
                        if (cyc >= 30) break;
                    end
                endcase
            end
        end

        @(posedge clk);
        #7;
        check("scoreboard_drained", sb.size(), 0);
        check("beats_out_eq_in", beats_out, beats_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_switch_custom.md
AXI4_SWITCH_CUSTOM -- requirements
Module: axi4_switch_custom

Interface
REQ-001 Parameters SHALL be:
- TDATA_L, default 512, data width.
- TUSER_L, default 81, user width.
- TKEEP_L, default 16, keep width.

REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_req_supress  in  2  bit n=1 masks new arbitration requests from slave port n.
- axi_s0_tdata_i / axi_s1_tdata_i  in  TDATA_L  slave data.
- axi_s0_tuser_i / axi_s1_tuser_i  in  TUSER_L  slave user.
- axi_s0_tlast_i / axi_s1_tlast_i  in  1  slave end of packet.
- axi_s0_tkeep_i / axi_s1_tkeep_i  in  TKEEP_L  slave keep.
- axi_s0_tvalid_i / axi_s1_tvalid_i  in  1  slave valid.
- axi_s0_tready_o / axi_s1_tready_o  out  1  slave ready.
- axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tlast_o, axi_m0_tkeep_o, axi_m0_tvalid_o  out  (widths as above)  master beat.
- axi_m0_tready_i  in  1  master ready.

Function
REQ-003 The block SHALL be a 2:1 AXI4-Stream packet switch; a transfer on any port occurs when tvalid and tready are both 1 on a rising clk edge.
REQ-004 The arbiter SHALL have three states: IDLE, LOCK0, LOCK1.
REQ-005 In IDLE, port n SHALL be eligible iff axi_sn_tvalid_i=1 and s_req_supress[n]=0.
REQ-006 In IDLE with one eligible port, that port SHALL be granted combinationally in the same cycle.
REQ-007 In IDLE with both ports eligible, the port holding round-robin priority SHALL be granted.
REQ-008 Round-robin priority SHALL move to the other port after each completed packet (the tlast beat is transferred).
REQ-009 In IDLE with no eligible port, there SHALL be no grant: m0 tvalid=0, both slave tready=0, and m0 data/user/keep/last outputs=0.
REQ-010 The granted port's tdata/tuser/tkeep/tlast/tvalid SHALL drive m0 with zero latency, and the granted port's tready SHALL equal axi_m0_tready_i.
REQ-011 The non-granted port's tready SHALL be 0.
REQ-012 On a transferred non-tlast beat in IDLE, state SHALL move to LOCKn of the granted port.
REQ-013 On a transferred tlast beat in IDLE, state SHALL remain IDLE and priority SHALL update.
REQ-014 In LOCKn, only port n SHALL be routed regardless of s_req_supress and the other port's tvalid; packets SHALL never interleave.
REQ-015 In LOCKn, a transferred tlast beat SHALL return state to IDLE and give priority to the other port.
REQ-016 A LOCKn state with tvalid=0 SHALL hold the lock with m0 tvalid=0.
REQ-017 With axi_m0_tready_i=0, the block SHALL drop no beat and SHALL pass m0 outputs through unchanged from the granted port.
REQ-018 A suppression change during a locked packet SHALL take effect at the next IDLE arbitration.

Reset
REQ-019 While rst_n=0 on a clk edge, state SHALL become IDLE and priority SHALL become port 0.
REQ-020 While rst_n=0, axi_s0_tready_o, axi_s1_tready_o and axi_m0_tvalid_o SHALL be forced to 0 combinationally.
REQ-021 Reset mid-packet SHALL abandon the lock; the next packet after reset SHALL be arbitrated fresh.

Configuration
REQ-022 Macro AXI4_SWITCH_CUSTOM_OUTREG_EN SHALL control a master-side output stage.
REQ-023 When AXI4_SWITCH_CUSTOM_OUTREG_EN is defined:
- m0 outputs SHALL come from a 2-entry skid register slice, so all m0 outputs are registered.
- Latency SHALL be 1 cycle with full throughput.
- Arbiter tready SHALL derive from slice space, not combinationally from axi_m0_tready_i.
- The slice SHALL be empty on reset.
REQ-024 When AXI4_SWITCH_CUSTOM_OUTREG_EN is undefined, the zero-latency path of REQ-010 SHALL apply.

Structure
REQ-025 Package axi4_switch_custom_pkg SHALL hold:
- the arbiter state enum typedef (IDLE/LOCK0/LOCK1);
- default width constants 512/81/16;
- port index constants 0/1.
REQ-026 The arbiter SHALL be a sub-module axi4_switch_custom_arb:
- inputs: requests, suppression, handshake, tlast;
- output: one-hot grant.
REQ-027 Data muxing and the optional slice SHALL reside in the top module.

Verification
REQ-028 s0 single beat, data 0xA0010001, user 0xB0010001, tlast=1, m0 tready=1 -> same-cycle m0 beat with equal data/user, tlast=1, s0 tready=1.
REQ-029 s1 sends 3-beat packet 0xA0050001..0xA0050003 while s0 is valid from beat 2 -> m0 carries all s1 beats contiguously, then s0; s0 tready=0 until the s1 tlast transfer.
REQ-030 Both ports valid simultaneously, 2-beat packets each, repeated twice -> m0 order s0,s1,s0,s1 after reset; no interleaving.
REQ-031 s_req_supress=2'b01, both valid -> only s1 served; clearing to 00 then lets s0 win next arbitration.
REQ-032 m0 tready=0 for 5 cycles mid-packet -> m0 outputs stable, no beat lost or duplicated; total beats out equals total beats in.
REQ-033 rst_n=0 for 1 cycle after a non-tlast beat -> all tready and m0 tvalid=0 during reset; next request arbitrated from IDLE with port 0 priority.
